// File: rtl/key_decoder_pkg.sv
// key_decoder_pkg: scancodes, direction encoding and control-word layout shared
// by the key decoder and its per-player trackers.
package key_decoder_pkg;

    // PS/2 set-2 scancodes, player 0
    localparam logic [7:0] SC_P0_UP    = 8'h1D;  // W
    localparam logic [7:0] SC_P0_LEFT  = 8'h1C;  // A
    localparam logic [7:0] SC_P0_DOWN  = 8'h1B;  // S
    localparam logic [7:0] SC_P0_RIGHT = 8'h23;  // D
    localparam logic [7:0] SC_P0_FIRE  = 8'h29;  // Space
    localparam logic [7:0] SC_P0_CHG   = 8'h15;  // Q

    // PS/2 set-2 scancodes, player 1
    localparam logic [7:0] SC_P1_UP    = 8'h43;  // I
    localparam logic [7:0] SC_P1_LEFT  = 8'h3B;  // J
    localparam logic [7:0] SC_P1_DOWN  = 8'h42;  // K
    localparam logic [7:0] SC_P1_RIGHT = 8'h4B;  // L
    localparam logic [7:0] SC_P1_FIRE  = 8'h3C;  // U
    localparam logic [7:0] SC_P1_CHG   = 8'h44;  // O

    // Game flow
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_ESC      = 8'h76;

    typedef enum logic [1:0] {
        UP    = 2'b00,
        LEFT  = 2'b01,
        DOWN  = 2'b10,
        RIGHT = 2'b11
    } dir_t;

    // Control word bit positions
    localparam int unsigned CHG    = 4;
    localparam int unsigned FIRE   = 3;
    localparam int unsigned MOVE   = 2;
    localparam int unsigned DIR_HI = 1;
    localparam int unsigned DIR_LO = 0;

    // Fixed fallback priority up > left > down > right; held[i] matches dir_t value i
    function automatic dir_t pick_dir(input logic [3:0] held);
        if (held[0])      return UP;
        else if (held[1]) return LEFT;
        else if (held[2]) return DOWN;
        else              return RIGHT;
    endfunction

endpackage

// File: rtl/player_key_tracker.sv
// player_key_tracker: held-key state, direction tracking and the frame-latched
// control word for one player.
// Build option: KEYMAP_OPPOSITE_CANCEL_EN suppresses is_move while opposing
// directions are held together.
module player_key_tracker
    import key_decoder_pkg::*;
#(
    parameter logic [7:0] KEY_UP    = SC_P0_UP,
    parameter logic [7:0] KEY_LEFT  = SC_P0_LEFT,
    parameter logic [7:0] KEY_DOWN  = SC_P0_DOWN,
    parameter logic [7:0] KEY_RIGHT = SC_P0_RIGHT,
    parameter logic [7:0] KEY_FIRE  = SC_P0_FIRE,
    parameter logic [7:0] KEY_CHG   = SC_P0_CHG
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    input  logic       press,
    input  logic       key_event,
    input  logic       frame_tick,
    output logic [4:0] ctrl
);

    // held bit layout: [3:0] directions indexed by dir_t, [4] fire, [5] change
    logic [5:0] held_q, held_d;
    logic [5:0] hit;
    dir_t       cur_dir_q, cur_dir_d;
    logic       change_req_q, change_req_d;
    logic       is_move;

    // Decode which of this player's keys the current event addresses
    always_comb begin
        hit    = '0;
        hit[0] = key_event && (keycode == KEY_UP);
        hit[1] = key_event && (keycode == KEY_LEFT);
        hit[2] = key_event && (keycode == KEY_DOWN);
        hit[3] = key_event && (keycode == KEY_RIGHT);
        hit[4] = key_event && (keycode == KEY_FIRE);
        hit[5] = key_event && (keycode == KEY_CHG);
    end

    // Next-state for held keys, direction and the sticky change request
    always_comb begin
        held_d       = held_q;
        cur_dir_d    = cur_dir_q;
        // The frame edge consumes the request; a same-cycle make re-arms it below
        change_req_d = change_req_q && !frame_tick;
        if (press) begin
            held_d = held_q | hit;
            // Repeats (key already held) leave everything untouched
            if (|(hit & ~held_q)) begin
                if (hit[0])      cur_dir_d = UP;
                else if (hit[1]) cur_dir_d = LEFT;
                else if (hit[2]) cur_dir_d = DOWN;
                else if (hit[3]) cur_dir_d = RIGHT;
                if (hit[5]) change_req_d = 1'b1;
            end
        end else begin
            held_d = held_q & ~hit;
            if (hit[cur_dir_q] && |held_d[3:0]) begin
                cur_dir_d = pick_dir(held_d[3:0]);
            end
        end
    end

    // Movement flag from the currently held direction keys
    always_comb begin
`ifdef KEYMAP_OPPOSITE_CANCEL_EN
        is_move = |held_q[3:0] &&
                  !((held_q[0] && held_q[2]) || (held_q[1] && held_q[3]));
`else
        is_move = |held_q[3:0];
`endif
    end

    // State registers; the output word only moves on the frame strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q       <= '0;
            cur_dir_q    <= UP;
            change_req_q <= 1'b0;
            ctrl         <= '0;
        end else begin
            held_q       <= held_d;
            cur_dir_q    <= cur_dir_d;
            change_req_q <= change_req_d;
            if (frame_tick) begin
                ctrl[CHG]           <= change_req_q;
                ctrl[FIRE]          <= held_q[4];
                ctrl[MOVE]          <= is_move;
                ctrl[DIR_HI:DIR_LO] <= cur_dir_q;
            end
        end
    end

endmodule

// File: rtl/key_decoder.sv
// key_decoder: turns PS/2 make/break events into per-player control words that
// are re-latched once per video frame, plus start/quit pulses.
// Build option: KEYMAP_OPPOSITE_CANCEL_EN (see player_key_tracker).
module key_decoder
    import key_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset_N,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       press,
    input  logic       key_event,
    output logic [4:0] player_0,
    output logic [4:0] player_1,
    output logic [1:0] CONTROL
);

    logic [SYNC_STAGES-1:0] frame_sync;
    logic                   frame_prev;
    logic                   frame_tick;
    logic                   enter_held, esc_held;
    logic                   enter_hit, esc_hit;

    // Synchronize VGA_VS into the Clk domain and remember the last sample
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            frame_sync <= '0;
            frame_prev <= 1'b0;
        end else begin
            frame_sync <= {frame_sync[SYNC_STAGES-2:0], frame_clk};
            frame_prev <= frame_sync[SYNC_STAGES-1];
        end
    end

    // Rising-edge strobe of the synchronized frame clock
    always_comb frame_tick = frame_sync[SYNC_STAGES-1] && !frame_prev;

    // Event decode for the game-flow keys
    always_comb begin
        enter_hit = key_event && (keycode == SC_ENTER);
        esc_hit   = key_event && (keycode == SC_ESC);
    end

    // Enter/Esc held tracking and one-cycle start/quit pulses on fresh makes
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            enter_held <= 1'b0;
            esc_held   <= 1'b0;
            CONTROL    <= 2'b00;
        end else begin
            CONTROL[0] <= enter_hit && press && !enter_held;
            CONTROL[1] <= esc_hit && press && !esc_held;
            if (enter_hit) enter_held <= press;
            if (esc_hit)   esc_held   <= press;
        end
    end

    player_key_tracker #(
        .KEY_UP    (SC_P0_UP),
        .KEY_LEFT  (SC_P0_LEFT),
        .KEY_DOWN  (SC_P0_DOWN),
        .KEY_RIGHT (SC_P0_RIGHT),
        .KEY_FIRE  (SC_P0_FIRE),
        .KEY_CHG   (SC_P0_CHG)
    ) u_player_0 (
        .clk        (Clk),
        .rst_n      (Reset_N),
        .keycode    (keycode),
        .press      (press),
        .key_event  (key_event),
        .frame_tick (frame_tick),
        .ctrl       (player_0)
    );

    player_key_tracker #(
        .KEY_UP    (SC_P1_UP),
        .KEY_LEFT  (SC_P1_LEFT),
        .KEY_DOWN  (SC_P1_DOWN),
        .KEY_RIGHT (SC_P1_RIGHT),
        .KEY_FIRE  (SC_P1_FIRE),
        .KEY_CHG   (SC_P1_CHG)
    ) u_player_1 (
        .clk        (Clk),
        .rst_n      (Reset_N),
        .keycode    (keycode),
        .press      (press),
        .key_event  (key_event),
        .frame_tick (frame_tick),
        .ctrl       (player_1)
    );

endmodule

// File: tb/tb_key_decoder.sv
// tb_key_decoder: directed and randomized checks of key_decoder against a
// key-table reference model.
module tb_key_decoder;

    localparam int SYNC = 2;

    logic       Clk = 1'b0;
    logic       Reset_N = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       press = 1'b0;
    logic       key_event = 1'b0;
    logic [4:0] player_0, player_1;
    logic [1:0] CONTROL;

    int errors = 0;
    int checks = 0;

    // Key table: 0..5 player 0 {up,left,down,right,fire,change}, 6..11 player 1, 12 Enter, 13 Esc
    logic [7:0] codes [14] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h15,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3C, 8'h44,
                               8'h5A, 8'h76};

    // Reference model state
    bit         held [14];
    logic [1:0] cur_dir [2];
    bit         chg_req [2];
    logic [4:0] exp_out [2];
    logic [1:0] exp_ctrl;

    key_decoder #(.SYNC_STAGES(SYNC)) dut (
        .Clk       (Clk),
        .Reset_N   (Reset_N),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .press     (press),
        .key_event (key_event),
        .player_0  (player_0),
        .player_1  (player_1),
        .CONTROL   (CONTROL)
    );

    always #10 Clk = ~Clk;

    function automatic int key_id(input logic [7:0] kc);
        for (int i = 0; i < 14; i++) if (codes[i] == kc) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 14; i++) held[i] = 0;
        for (int p = 0; p < 2; p++) begin
            cur_dir[p] = 2'd0;
            chg_req[p] = 0;
            exp_out[p] = 5'd0;
        end
        exp_ctrl = 2'b00;
    endtask

    // Apply one event to the model; exp_ctrl gets the pulse it should cause
    task automatic model_event(input logic [7:0] kc, input logic pr);
        int id, p, k;
        exp_ctrl = 2'b00;
        id = key_id(kc);
        if (id < 0) return;
        if (pr && held[id]) return;  // typematic repeat
        held[id] = pr;
        if (id == 12) begin
            if (pr) exp_ctrl = 2'b01;
            return;
        end
        if (id == 13) begin
            if (pr) exp_ctrl = 2'b10;
            return;
        end
        p = id / 6;
        k = id % 6;
        if (pr) begin
            if (k < 4) cur_dir[p] = 2'(k);
            if (k == 5) chg_req[p] = 1;
        end else if (k < 4 && int'(cur_dir[p]) == k) begin
            for (int d = 0; d < 4; d++) begin
                if (held[p*6+d]) begin
                    cur_dir[p] = 2'(d);
                    break;
                end
            end
        end
    endtask

    function automatic logic [4:0] snap(input int p);
        int  b;
        bit  mv;
        b  = p * 6;
        mv = held[b] || held[b+1] || held[b+2] || held[b+3];
`ifdef KEYMAP_OPPOSITE_CANCEL_EN
        if ((held[b] && held[b+2]) || (held[b+1] && held[b+3])) mv = 0;
`endif
        return {chg_req[p], held[b+4], mv, cur_dir[p]};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts and ends at a falling edge
    task automatic send_event(input logic [7:0] kc, input logic pr);
        model_event(kc, pr);
        keycode   = kc;
        press     = pr;
        key_event = 1'b1;
        @(negedge Clk);
        key_event = 1'b0;
        check("control_pulse", {6'd0, CONTROL}, {6'd0, exp_ctrl});
        check("p0_between_frames", {3'd0, player_0}, {3'd0, exp_out[0]});
        check("p1_between_frames", {3'd0, player_1}, {3'd0, exp_out[1]});
        @(negedge Clk);
        check("control_one_cycle", {6'd0, CONTROL}, 8'd0);
    endtask

    // Frame edge; optionally collide an event with the detected-edge cycle
    task automatic frame_edge(input bit collide, input logic [7:0] kc, input logic pr);
        frame_clk = 1'b1;
        repeat (SYNC) @(posedge Clk);
        @(negedge Clk);
        check("p0_before_latch", {3'd0, player_0}, {3'd0, exp_out[0]});
        check("p1_before_latch", {3'd0, player_1}, {3'd0, exp_out[1]});
        exp_out[0] = snap(0);
        exp_out[1] = snap(1);
        chg_req[0] = 0;
        chg_req[1] = 0;
        exp_ctrl   = 2'b00;
        if (collide) begin
            model_event(kc, pr);
            keycode   = kc;
            press     = pr;
            key_event = 1'b1;
        end
        @(negedge Clk);
        key_event = 1'b0;
        check("p0_latched", {3'd0, player_0}, {3'd0, exp_out[0]});
        check("p1_latched", {3'd0, player_1}, {3'd0, exp_out[1]});
        check("control_at_edge", {6'd0, CONTROL}, {6'd0, exp_ctrl});
        frame_clk = 1'b0;
        repeat (SYNC + 2) @(negedge Clk);
        check("control_after_edge", {6'd0, CONTROL}, 8'd0);
    endtask

    initial begin
        logic [7:0] kc;
        logic       pr;
        int         r;

        model_reset();

        // Reset idle
        repeat (3) @(negedge Clk);
        check("reset_p0", {3'd0, player_0}, 8'd0);
        check("reset_p1", {3'd0, player_1}, 8'd0);
        check("reset_control", {6'd0, CONTROL}, 8'd0);
        Reset_N = 1'b1;
        @(negedge Clk);
        frame_edge(0, 8'h00, 1'b0);
        frame_edge(0, 8'h00, 1'b0);
        check("idle_p0", {3'd0, player_0}, 8'd0);

        // Direction priority
        send_event(8'h1D, 1'b1);
        send_event(8'h1C, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
        check("dir_recent_wins", {3'd0, player_0}, 8'b00101);
        send_event(8'h1C, 1'b0);
        frame_edge(0, 8'h00, 1'b0);
        check("dir_fallback_up", {3'd0, player_0}, 8'b00100);
        send_event(8'h1D, 1'b0);
        frame_edge(0, 8'h00, 1'b0);
        check("dir_released", {3'd0, player_0}, 8'b00000);

        // Change one-shot with typematic repeats
        repeat (3) send_event(8'h15, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
        check("change_set", {7'd0, player_0[4]}, 8'd1);
        frame_edge(0, 8'h00, 1'b0);
        check("change_one_frame", {7'd0, player_0[4]}, 8'd0);
        send_event(8'h15, 1'b0);
        send_event(8'h15, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
        check("change_again", {7'd0, player_0[4]}, 8'd1);
        send_event(8'h15, 1'b0);

        // Start/quit pulses
        send_event(8'h5A, 1'b1);
        send_event(8'h5A, 1'b1);
        send_event(8'h5A, 1'b0);
        send_event(8'h76, 1'b1);
        send_event(8'h76, 1'b0);

        // Event/edge collision
        frame_edge(1, 8'h29, 1'b1);
        check("collide_fire_late", {7'd0, player_0[3]}, 8'd0);
        frame_edge(0, 8'h00, 1'b0);
        check("collide_fire_next", {7'd0, player_0[3]}, 8'd1);
        send_event(8'h29, 1'b0);
        // Change request arriving on the edge survives into the next frame
        frame_edge(1, 8'h44, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
        check("collide_change", {7'd0, player_1[4]}, 8'd1);
        send_event(8'h44, 1'b0);
        frame_edge(0, 8'h00, 1'b0);

        // Opposite cancel
        send_event(8'h43, 1'b1);
        send_event(8'h42, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
`ifdef KEYMAP_OPPOSITE_CANCEL_EN
        check("opposite_p1", {3'd0, player_1}, 8'b00010);
`else
        check("opposite_p1", {3'd0, player_1}, 8'b00110);
`endif
        send_event(8'h43, 1'b0);
        send_event(8'h42, 1'b0);

        // Reset mid-frame clears immediately
        send_event(8'h1B, 1'b1);
        send_event(8'h29, 1'b1);
        frame_edge(0, 8'h00, 1'b0);
        frame_clk = 1'b1;
        @(posedge Clk);
        #3 Reset_N = 1'b0;
        #1;
        model_reset();
        check("async_reset_p0", {3'd0, player_0}, 8'd0);
        check("async_reset_ctrl", {6'd0, CONTROL}, 8'd0);
        @(negedge Clk);
        Reset_N   = 1'b1;
        frame_clk = 1'b0;
        repeat (SYNC + 2) @(negedge Clk);
        frame_edge(0, 8'h00, 1'b0);
        check("post_reset_idle", {3'd0, player_0}, 8'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r  = int'($urandom_range(0, 9));
            kc = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                             : codes[$urandom_range(0, 13)];
            pr = ($urandom_range(0, 2) != 0);
            if (r < 7)       send_event(kc, pr);
            else if (r == 7) frame_edge(0, 8'h00, 1'b0);
            else             frame_edge(1, kc, pr);
        end
        frame_edge(0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
